// File: rtl/enc_sched_pkg.sv
// Shared types for the serial-encoder frame scheduler.
// FSM state encoding and index-width helper.
package enc_sched_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLR   = 3'd1,
        S_SHIFT = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/enc_frame_sched_rr_arbiter.sv
// Rotating-priority arbiter: first requester at or after ptr wins.
// Purely combinational.
module rr_arbiter
    import enc_sched_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]         req,
    input  logic [idx_w(NREQ)-1:0]  ptr,
    output logic                    gnt_vld,
    output logic [idx_w(NREQ)-1:0]  gnt_idx
);

    localparam int IW = idx_w(NREQ);

    logic [IW:0] s;

    // Walk offsets from farthest to nearest so the nearest hit wins.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        s       = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            s = {1'b0, ptr} + (IW+1)'(i);
            if (s >= (IW+1)'(NREQ))
                s = s - (IW+1)'(NREQ);
            if (req[s[IW-1:0]]) begin
                gnt_vld = 1'b1;
                gnt_idx = s[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/enc_frame_sched.sv
// Round-robin scheduler feeding frames through one shared
// serial encoder and returning the encoded word with an ack.
module enc_frame_sched
    import enc_sched_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*WIDTH-1:0]   data,
    output logic [NREQ-1:0]         ack,
    output logic [WIDTH-1:0]        result,
    output logic [idx_w(NREQ)-1:0]  result_id,
    output logic                    busy,
    output logic                    enc_rst,
    output logic                    enc_xin,
    input  logic                    enc_yout
);

    localparam int IW = idx_w(NREQ);
    localparam int CW = idx_w(WIDTH);

    state_t           state;
    logic [IW-1:0]    ptr;
    logic [IW-1:0]    gid;
    logic [IW-1:0]    gnt_idx;
    logic             gnt_vld;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] rx;
    logic [WIDTH-1:0] rx_nxt;
    logic [WIDTH-1:0] word;
    logic [IW-1:0]    ptr_nxt;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req     (req),
        .ptr     (ptr),
        .gnt_vld (gnt_vld),
        .gnt_idx (gnt_idx)
    );

    assign word    = data[int'(gnt_idx)*WIDTH +: WIDTH];
    assign rx_nxt  = {enc_yout, rx[WIDTH-1:1]};
    assign ptr_nxt = (gnt_idx == IW'(NREQ - 1)) ? '0
                                                 : gnt_idx + IW'(1);

    assign busy    = (state != S_IDLE);
    // Our own reset also holds the encoder in clear.
    assign enc_rst = rst & (state != S_CLR);
    assign enc_xin = (state == S_SHIFT) & shreg[0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            ptr       <= '0;
            gid       <= '0;
            cnt       <= '0;
            shreg     <= '0;
            rx        <= '0;
            ack       <= '0;
            result    <= '0;
            result_id <= '0;
        end else begin
            ack <= '0;
            unique case (state)
                S_IDLE: begin
                    if (gnt_vld) begin
                        gid   <= gnt_idx;
                        shreg <= word;
                        ptr   <= ptr_nxt;
                        state <= S_CLR;
                    end
                end
                S_CLR: begin
                    cnt   <= '0;
                    state <= S_SHIFT;
                end
                S_SHIFT: begin
                    shreg <= shreg >> 1;
                    cnt   <= cnt + CW'(1);
                    // Encoder output lags input by one cycle.
                    if (cnt != '0)
                        rx <= rx_nxt;
                    if (cnt == CW'(WIDTH - 1))
                        state <= S_DRAIN;
                end
                S_DRAIN: begin
                    rx        <= rx_nxt;
                    result    <= rx_nxt;
                    result_id <= gid;
                    ack       <= NREQ'(1) << gid;
                    state     <= S_DONE;
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_enc_frame_sched.sv
// Scoreboard bench for enc_frame_sched with a behavioural encoder.
// Stimulus pushes expected acks; a negedge monitor pops and checks.
module tb_enc_frame_sched;

    localparam int NREQ  = 4;
    localparam int WIDTH = 8;

    logic                  clk;
    logic                  rst;
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] data;
    logic [NREQ-1:0]       ack;
    logic [WIDTH-1:0]      result;
    logic [1:0]            result_id;
    logic                  busy;
    logic                  enc_rst;
    logic                  enc_xin;
    logic                  enc_yout;

    enc_frame_sched #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .data      (data),
        .ack       (ack),
        .result    (result),
        .result_id (result_id),
        .busy      (busy),
        .enc_rst   (enc_rst),
        .enc_xin   (enc_xin),
        .enc_yout  (enc_yout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Shared encoder: registered y = x ^ running parity, sync clear.
    logic par = 1'b0;
    initial enc_yout = 1'b0;
    always @(posedge clk) begin
        if (!enc_rst) begin
            enc_yout <= 1'b0;
            par      <= 1'b0;
        end else begin
            enc_yout <= enc_xin ^ par;
            par      <= par ^ enc_xin;
        end
    end

    typedef struct {
        int         id;
        logic [7:0] res;
        int         at;
    } exp_t;

    exp_t q[$];
    int total = 0;
    int bad   = 0;
    int clr_cnt = 0;

    function automatic logic [7:0] enc_model(input logic [7:0] x);
        logic [7:0] y;
        logic p;
        y = '0;
        p = 1'b0;
        for (int i = 0; i < 8; i++) begin
            y[i] = x[i] ^ p;
            p    = p ^ x[i];
        end
        return y;
    endfunction

    task automatic chk(input string nm, input int act, input int req_v);
        total++;
        if (act != req_v) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", nm, act, req_v);
        end
    endtask

    task automatic push(input int id, input logic [7:0] res, input int at);
        exp_t e;
        e.id  = id;
        e.res = res;
        e.at  = at;
        q.push_back(e);
    endtask

    task automatic wait_drain(input int bound);
        int k = 0;
        while (q.size() != 0 && k < bound) begin
            @(negedge clk);
            k++;
        end
        chk("drain_pending", q.size(), 0);
        q.delete();
        repeat (2) @(negedge clk);
    endtask

    // Issue one single-requester frame; req dropped after grant.
    task automatic frame(input int id, input logic [7:0] d,
                         input logic [7:0] exp_res);
        int n;
        data[id*WIDTH +: WIDTH] = d;
        req = NREQ'(1) << id;
        n = cyc;
        push(id, exp_res, n + 11);
        @(negedge clk);
        req = '0;
        wait_drain(40);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst)
            clr_cnt = 0;
        else if (!enc_rst)
            clr_cnt++;
        if (ack != '0) begin
            if (q.size() == 0) begin
                chk("unexpected_ack", int'(ack), 0);
            end else begin
                e = q.pop_front();
                chk("ack", int'(ack), 1 << e.id);
                chk("result", int'(result), int'(e.res));
                chk("result_id", int'(result_id), e.id);
                chk("ack_cycle", cyc, e.at);
                chk("clr_cycles", clr_cnt, 1);
            end
            clr_cnt = 0;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst  = 1'b0;
        req  = '0;
        data = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_ack", int'(ack), 0);
        chk("rst_result", int'(result), 0);
        chk("rst_result_id", int'(result_id), 0);
        chk("rst_enc_rst", int'(enc_rst), 0);
        chk("rst_enc_xin", int'(enc_xin), 0);
        rst = 1'b1;
        @(negedge clk);
        chk("idle_enc_rst", int'(enc_rst), 1);

        // Single request and encoding values (hand-computed).
        frame(0, 8'h01, 8'hFF);
        frame(0, 8'h03, 8'h01);
        frame(0, 8'h00, 8'h00);
        frame(0, 8'hFF, 8'h55);

        // Move ptr to 3 via requester 2, then wrap and skip.
        frame(2, 8'h3C, enc_model(8'h3C));
        data[0*WIDTH +: WIDTH] = 8'h5A;
        data[2*WIDTH +: WIDTH] = 8'hC3;
        req = 4'b0101;
        n = cyc;
        push(0, enc_model(8'h5A), n + 11);
        push(2, enc_model(8'hC3), n + 23);
        repeat (13) @(negedge clk);
        req = '0;
        wait_drain(60);

        // Mid-frame reset at SHIFT cnt=4.
        data[1*WIDTH +: WIDTH] = 8'h77;
        req = 4'b0010;
        @(negedge clk);
        req = '0;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_enc_rst", int'(enc_rst), 0);
        chk("midrst_ack", int'(ack), 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        frame(1, 8'hA5, 8'h63);

        // Reset pulse so the fairness sweep starts at ptr=0.
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        data[0*WIDTH +: WIDTH] = 8'h11;
        data[1*WIDTH +: WIDTH] = 8'h22;
        data[2*WIDTH +: WIDTH] = 8'h96;
        data[3*WIDTH +: WIDTH] = 8'h80;
        req = 4'b1111;
        n = cyc;
        push(0, enc_model(8'h11), n + 11);
        push(1, enc_model(8'h22), n + 23);
        push(2, enc_model(8'h96), n + 35);
        push(3, enc_model(8'h80), n + 47);
        push(0, enc_model(8'h11), n + 59);
        repeat (49) @(negedge clk);
        req = '0;
        wait_drain(80);

        // req dropped and data changed right after grant.
        data[3*WIDTH +: WIDTH] = 8'h0F;
        req = 4'b1000;
        n = cyc;
        push(3, 8'h05, n + 11);
        @(negedge clk);
        req = '0;
        data[3*WIDTH +: WIDTH] = 8'hF0;
        wait_drain(40);

        repeat (15) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/enc_frame_sched.md
Name: enc_frame_sched

Overview:
- Schedules one shared serial Mealy encoder among NREQ requesters. The encoder is 1 bit in, 1 bit registered out, with synchronous active-low clear. Its function is y_i = x_i XOR parity(x_0..x_{i-1}); parity is reset to 0 by the clear.
- Grants requesters round-robin, clears the encoder, serializes the granted WIDTH-bit word LSB-first into it, collects the encoded bits back into a word, and returns that word with a one-cycle ack.
- Sits between requester logic and a single encoder instance.

Parameters:
- NREQ, 4, number of requesters (2..8).
- WIDTH, 8, frame width in bits (2..32).

Ports:
- clk  input  1  system clock, all flops on posedge.
- rst  input  1  asynchronous active-low reset; all state is cleared immediately on assertion.
- req  input  NREQ  per-requester request level; sampled only in IDLE.
- data  input  NREQ*WIDTH  requester i word at data[i*WIDTH +: WIDTH]; sampled only on the grant cycle.
- ack  output  NREQ  one-hot one-cycle pulse; frame of requester i complete.
- result  output  WIDTH  encoded word; valid only while ack != 0.
- result_id  output  $clog2(NREQ)  index of the acked requester.
- busy  output  1  high in every state except IDLE.
- enc_rst  output  1  active-low clear to the encoder.
- enc_xin  output  1  serial bit to the encoder.
- enc_yout  input  1  registered encoder output.

Behaviour:
- States: IDLE, CLR, SHIFT, DRAIN, DONE. State encoding constants live in the package.
- IDLE
  - If any req is high, the rr_arbiter picks a grant starting from ptr.
  - Latch grant into gid, data[gid] into shreg, and set ptr <= gid+1 mod NREQ. Next state is CLR.
  - Otherwise stay in IDLE.
- CLR (1 cycle)
  - enc_rst=0, so the encoder clears at the closing edge.
  - cnt <= 0. Next state is SHIFT.
- SHIFT (WIDTH cycles)
  - enc_xin = shreg[0]. At each edge: shreg >>= 1 and cnt++.
  - When cnt > 0: rx <= {enc_yout, rx[WIDTH-1:1]}.
  - After the cycle with cnt == WIDTH-1, next state is DRAIN.
- DRAIN (1 cycle)
  - Final capture rx <= {enc_yout, rx[WIDTH-1:1]}. Next state is DONE.
  - rx[i] now holds the encoded bit i.
- DONE (1 cycle)
  - ack[gid]=1, result=rx, result_id=gid. Next state is IDLE.
- Latency: from the IDLE grant cycle to ack is WIDTH+3 cycles. Minimum request-to-request period is WIDTH+4 cycles.
- enc_xin is 0 outside SHIFT.
- enc_rst = rst AND (state != CLR). It is therefore low during our reset, which also clears the encoder.
- Reset values:
  - state=IDLE, ptr=0, gid=0, cnt=0, shreg=0, rx=0.
  - ack=0, result=0, result_id=0, busy=0, enc_xin=0, enc_rst=0 while rst is low.
- Round-robin:
  - The search starts at ptr and wraps past NREQ-1 to 0.
  - A single requester holding req continuously is re-served back-to-back. No starvation: any waiting requester is served within NREQ frames.
- req is ignored outside IDLE. Deasserting req mid-frame does not abort the frame; ack is still issued.
- A requester that keeps req high in the IDLE after its ack is treated as a new request.
- data changes after the grant cycle have no effect.
- Reset asserted mid-frame:
  - Immediate return to IDLE with no ack; the in-flight frame is discarded.
  - After release, the first grant starts at requester 0.
- The controller owns the encoder exclusively. A fresh CLR precedes every frame, so parity never carries over between frames.

Decomposition:
- Package enc_sched_pkg: state encoding constants (IDLE..DONE); helper function for the index width.
- Sub-module rr_arbiter (NREQ): inputs req and ptr; outputs grant valid and grant index. Combinational priority rotate.

Test Plan:
- Single request: req=0001, data0=8'h01 → after 11 cycles ack=0001, result=8'hFF, result_id=0. Bench encoder model confirms enc_rst was low for exactly 1 cycle.
- Encoding values: data0=8'h03 → 8'h01; 8'h00 → 8'h00; 8'hFF → 8'h55. Same frame timing in each case.
- Fairness: req=1111 held with distinct data → acks in order 0,1,2,3,0, each 12 cycles apart. Each result matches the XOR-prefix-parity model.
- Wrap and skip: ptr=3, req=0101 → grant 0 then 2, never 3 or 1.
- Mid-frame reset: assert rst during SHIFT cnt=4 → busy=0 and enc_rst=0 immediately, no ack. After release, a new frame on req=0010 returns the correct result.
- req dropped mid-frame and data changed after grant → ack still issued, result computed from the latched data.
